d1_decode: RTL and testbench

- First decode stage (D1) of the frontend, between the instruction buffer and later decode.
- Owns the fetch PC and latches one 32-bit instruction per cycle from IBuff_in.
- Classifies the instruction and performs early redirection: JAL, gshare-predicted conditional branches, and JALR via a return address stack (RAS) or an indirect-target register.
- Applies external resteers and trains the predictor from branch-resolution updates.

---
 rtl/d1_decode_pkg.sv | 40 ++++
 rtl/d1_decode_ras.sv | 39 +++
 rtl/d1_decode.sv | 168 ++++++++++++++++
 tb/tb_d1_decode.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/d1_decode_pkg.sv
// Shared frontend definitions for the D1 decode stage: opcodes, instruction
// classes, the link-register predicate and immediate extraction.
package d1_decode_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CLS_OTHER,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH
    } instr_class_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic instr_class_e classify(input logic [6:0] op);
        instr_class_e cls;
        case (op)
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_BRANCH: cls = CLS_BRANCH;
            default:   cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    // Immediates are returned already shifted and sign-extended to 32 bits.
    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/d1_decode_ras.sv
// Circular return address stack; overflow overwrites the oldest entry and
// underflow simply wraps the pointer.
module d1_ras #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]   ptr;
    logic [XLEN-1:0] entries [DEPTH];

    assign top = entries[ptr];

    // A simultaneous pop and push replaces the top entry in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && pop) begin
            entries[ptr] <= push_addr;
        end else if (push) begin
            ptr                  <= ptr + 1'b1;
            entries[ptr + 1'b1]  <= push_addr;
        end else if (pop) begin
            ptr <= ptr - 1'b1;
        end
    end

endmodule

// File: rtl/d1_decode.sv
// D1 decode stage: owns the fetch PC, latches one instruction per cycle and
// redirects early on JAL, gshare-predicted branches and JALR.
module d1_decode
    import d1_decode_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 8,
    parameter int              BHR_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exception_in,
    input  logic [XLEN-1:0]  IBuff_in,
    input  logic             resteer,
    input  logic [XLEN-1:0]  resteer_target_BR,
    input  logic [XLEN-1:0]  resteer_target_ROB,
    input  logic             bp_update,
    input  logic             bp_update_taken,
    input  logic [XLEN-1:0]  bp_update_target,
    input  logic [BHR_W-1:0] pcbp_update_bhr,
    output logic [XLEN-1:0]  pc,
    output logic             exception_out,
    output logic [4:0]       opcode_format,
    output logic [XLEN-1:0]  instruction_out,
    output logic             resteer_D1,
    output logic [XLEN-1:0]  resteer_target_D1,
    output logic             resteer_taken,
    output logic [BHR_W-1:0] clbp_update_bhr_D1,
    output logic             ras_push,
    output logic             ras_pop,
    output logic [XLEN-1:0]  ras_ret_addr
);

    localparam int PHT_N = 1 << BHR_W;

    logic [XLEN-1:0]  pc_q;
    logic             valid;
    logic [XLEN-1:0]  stage_pc;
    logic [XLEN-1:0]  stage_instr;
    logic             stage_exc;
    logic [BHR_W-1:0] bhr;
    logic [1:0]       pht [PHT_N];
    logic [XLEN-1:0]  itr;
    logic [XLEN-1:0]  ras_top;

    logic [31:0]      instr;
    logic [XLEN-1:0]  pc_plus4;
    logic [BHR_W-1:0] idx;
    logic [4:0]       rd;
    logic [4:0]       rs1;

    assign instr    = stage_instr[31:0];
    assign pc_plus4 = stage_pc + XLEN'(4);
    assign idx      = bhr ^ stage_pc[BHR_W+1:2];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];

    always_comb begin
        pc                 = '0;
        instruction_out    = '0;
        opcode_format      = '0;
        exception_out      = 1'b0;
        resteer_D1         = 1'b0;
        resteer_taken      = 1'b0;
        resteer_target_D1  = '0;
        clbp_update_bhr_D1 = '0;
        ras_push           = 1'b0;
        ras_pop            = 1'b0;
        ras_ret_addr       = '0;
        if (valid) begin
            pc                = stage_pc;
            instruction_out   = stage_instr;
            opcode_format     = instr[6:2];
            exception_out     = stage_exc | (instr[1:0] != 2'b11);
            resteer_target_D1 = pc_plus4;
            unique case (classify(instr[6:0]))
                CLS_JAL: begin
                    resteer_D1        = 1'b1;
                    resteer_taken     = 1'b1;
                    resteer_target_D1 = stage_pc + XLEN'($signed(j_imm(instr)));
                    ras_push          = is_link(rd);
                end
                CLS_BRANCH: begin
                    clbp_update_bhr_D1 = idx;
                    if (pht[idx][1]) begin
                        resteer_D1        = 1'b1;
                        resteer_taken     = 1'b1;
                        resteer_target_D1 = stage_pc + XLEN'($signed(b_imm(instr)));
                    end
                end
                CLS_JALR: begin
                    resteer_D1    = 1'b1;
                    resteer_taken = 1'b1;
                    // A coroutine swap (rd == rs1, both links) pushes without popping.
                    ras_pop       = is_link(rs1) && !(is_link(rd) && (rd == rs1));
                    ras_push      = is_link(rd);
                    resteer_target_D1 = ras_pop ? ras_top : itr;
                end
                CLS_OTHER: begin
                end
            endcase
            if (ras_push) begin
                ras_ret_addr = pc_plus4;
            end
        end
    end

    // Either redirect source squashes the word being fetched this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            valid       <= 1'b0;
            stage_pc    <= '0;
            stage_instr <= '0;
            stage_exc   <= 1'b0;
        end else begin
            if (resteer) begin
                pc_q <= exception_in ? resteer_target_ROB : resteer_target_BR;
            end else if (resteer_D1) begin
                pc_q <= resteer_target_D1;
            end else begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (resteer || resteer_D1) begin
                valid <= 1'b0;
            end else begin
                valid       <= 1'b1;
                stage_pc    <= pc_q;
                stage_instr <= IBuff_in;
                stage_exc   <= exception_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bhr <= '0;
            itr <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (bp_update) begin
            bhr <= {bhr[BHR_W-2:0], bp_update_taken};
            if (bp_update_taken) begin
                itr <= bp_update_target;
                if (pht[pcbp_update_bhr] != 2'b11) begin
                    pht[pcbp_update_bhr] <= pht[pcbp_update_bhr] + 2'b01;
                end
            end else if (pht[pcbp_update_bhr] != 2'b00) begin
                pht[pcbp_update_bhr] <= pht[pcbp_update_bhr] - 2'b01;
            end
        end
    end

    d1_ras #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (pc_plus4),
        .top       (ras_top)
    );

endmodule

// File: tb/tb_d1_decode.sv
// Directed bench for d1_decode: reset, sequential fetch, JAL/JALR with the RAS,
// external resteers, fault tagging and gshare training.
module tb_d1_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_in;
    logic [31:0] IBuff_in;
    logic        resteer;
    logic [31:0] resteer_target_BR;
    logic [31:0] resteer_target_ROB;
    logic        bp_update;
    logic        bp_update_taken;
    logic [31:0] bp_update_target;
    logic [9:0]  pcbp_update_bhr;
    logic [31:0] pc;
    logic        exception_out;
    logic [4:0]  opcode_format;
    logic [31:0] instruction_out;
    logic        resteer_D1;
    logic [31:0] resteer_target_D1;
    logic        resteer_taken;
    logic [9:0]  clbp_update_bhr_D1;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_ret_addr;

    int total_checks = 0;
    int bad_checks   = 0;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_X1   = 32'h0080_00EF;
    localparam logic [31:0] RET      = 32'h0000_8067;
    localparam logic [31:0] JALR_X2  = 32'h0001_0067;
    localparam logic [31:0] BEQ_P16  = 32'h0000_0863;
    localparam logic [31:0] BAD_WORD = 32'hA5A5_A5A5;

    always #5 clk = ~clk;

    d1_decode dut (
        .clk                (clk),
        .rst                (rst),
        .exception_in       (exception_in),
        .IBuff_in           (IBuff_in),
        .resteer            (resteer),
        .resteer_target_BR  (resteer_target_BR),
        .resteer_target_ROB (resteer_target_ROB),
        .bp_update          (bp_update),
        .bp_update_taken    (bp_update_taken),
        .bp_update_target   (bp_update_target),
        .pcbp_update_bhr    (pcbp_update_bhr),
        .pc                 (pc),
        .exception_out      (exception_out),
        .opcode_format      (opcode_format),
        .instruction_out    (instruction_out),
        .resteer_D1         (resteer_D1),
        .resteer_target_D1  (resteer_target_D1),
        .resteer_taken      (resteer_taken),
        .clbp_update_bhr_D1 (clbp_update_bhr_D1),
        .ras_push           (ras_push),
        .ras_pop            (ras_pop),
        .ras_ret_addr       (ras_ret_addr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic exc,
                                 input logic rs, input logic [31:0] br,
                                 input logic [31:0] rob);
        IBuff_in           = instr;
        exception_in       = exc;
        resteer            = rs;
        resteer_target_BR  = br;
        resteer_target_ROB = rob;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b0;
        bp_update        = 1'b0;
        bp_update_taken  = 1'b0;
        bp_update_target = '0;
        pcbp_update_bhr  = '0;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instruction_out, 32'h0);
        checkOutput("rst_exc", 32'(exception_out), 32'h0);
        checkOutput("rst_resteer", 32'(resteer_D1), 32'h0);
        checkOutput("rst_ret", ras_ret_addr, 32'h0);

        rst = 1'b1;
        applyStimulus(NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("seq_pc0", pc, 32'h0);
        checkOutput("seq_opfmt", 32'(opcode_format), 32'h4);
        checkOutput("seq_resteer", 32'(resteer_D1), 32'h0);
        tick();
        checkOutput("seq_pc4", pc, 32'h4);
        tick();
        checkOutput("seq_pc8", pc, 32'h8);

        // Mid-run async reset must clear outputs without a clock edge.
        rst = 1'b0;
        #1;
        checkOutput("async_rst_pc", pc, 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(JAL_X1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("jal_pc", pc, 32'h0);
        checkOutput("jal_resteer", 32'(resteer_D1), 32'h1);
        checkOutput("jal_taken", 32'(resteer_taken), 32'h1);
        checkOutput("jal_target", resteer_target_D1, 32'h8);
        checkOutput("jal_push", 32'(ras_push), 32'h1);
        checkOutput("jal_ret", ras_ret_addr, 32'h4);
        applyStimulus(RET, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("jal_bubble", 32'(resteer_D1), 32'h0);
        tick();
        checkOutput("ret_pc", pc, 32'h8);
        checkOutput("ret_pop", 32'(ras_pop), 32'h1);
        checkOutput("ret_push", 32'(ras_push), 32'h0);
        checkOutput("ret_target", resteer_target_D1, 32'h4);
        checkOutput("ret_retaddr", ras_ret_addr, 32'h0);
        applyStimulus(NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("ret_landing", pc, 32'h4);

        applyStimulus(NOP, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        tick();
        checkOutput("br_squash_pc", pc, 32'h0);
        checkOutput("br_squash_instr", instruction_out, 32'h0);
        applyStimulus(NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("br_redirect", pc, 32'h1234_5678);

        applyStimulus(NOP, 1'b1, 1'b1, 32'h1111_1111, 32'h8765_4321);
        tick();
        checkOutput("rob_squash_pc", pc, 32'h0);
        applyStimulus(BAD_WORD, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rob_redirect", pc, 32'h8765_4321);
        checkOutput("bad_exc", 32'(exception_out), 32'h1);
        checkOutput("bad_opfmt", 32'(opcode_format), 32'h9);
        checkOutput("bad_instr", instruction_out, BAD_WORD);

        applyStimulus(NOP, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
        tick();
        applyStimulus(BEQ_P16, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("bnt_pc", pc, 32'h100);
        checkOutput("bnt_resteer", 32'(resteer_D1), 32'h0);
        checkOutput("bnt_taken", 32'(resteer_taken), 32'h0);
        checkOutput("bnt_target", resteer_target_D1, 32'h104);
        checkOutput("bnt_idx", 32'(clbp_update_bhr_D1), 32'h40);

        // Two taken updates: counter 01->10->11, BHR becomes 0b11.
        applyStimulus(NOP, 1'b0, 1'b0, 32'h0, 32'h0);
        bp_update        = 1'b1;
        bp_update_taken  = 1'b1;
        bp_update_target = 32'hDEAD_0000;
        pcbp_update_bhr  = 10'h083;
        tick();
        tick();
        bp_update = 1'b0;
        applyStimulus(NOP, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
        tick();
        applyStimulus(BEQ_P16, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("bt_pc", pc, 32'h200);
        checkOutput("bt_resteer", 32'(resteer_D1), 32'h1);
        checkOutput("bt_taken", 32'(resteer_taken), 32'h1);
        checkOutput("bt_target", resteer_target_D1, 32'h210);
        checkOutput("bt_idx", 32'(clbp_update_bhr_D1), 32'h83);
        applyStimulus(JALR_X2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("ind_pc", pc, 32'h210);
        checkOutput("ind_resteer", 32'(resteer_D1), 32'h1);
        checkOutput("ind_pop", 32'(ras_pop), 32'h0);
        checkOutput("ind_target", resteer_target_D1, 32'hDEAD_0000);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
